// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the inter-stage pipeline register
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int NOP_TYPE = 0;

    localparam int IF_ID_DATA_W  = 96;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_DATA_W = 64;
    localparam int PIPE_TYPE_W   = 4;
    localparam int PIPE_CNT_W    = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready beat channel carrying payload and instruction type
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int TYPE_W = 4
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [TYPE_W-1:0] ntype;

    modport master (output valid, output data, output ntype, input ready);
    modport slave  (input valid, input data, input ntype, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, cleared only by reset
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment on event, sticking at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with handshake, optional skid, flush and perf counters
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int TYPE_W = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  in_if,
    pipe_stage_reg_if.master out_if,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
);
    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [TYPE_W-1:0] main_type_q, main_type_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [TYPE_W-1:0] skid_type_q, skid_type_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic drain;

    // With a skid entry in_ready comes purely from state; without it, a drain frees the slot same-cycle
    assign in_ready  = (SKID != 0) ? (state_q != FULL)
                                   : ((state_q == EMPTY) || out_if.ready);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_if.valid && in_ready && !flush;
    assign drain     = out_valid && out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_data_q;
    assign out_if.ntype = out_valid ? main_type_q : TYPE_W'(NOP_TYPE);

    // Occupancy FSM: main register always feeds the output, skid only refills main
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_type_d = main_type_q;
        skid_data_d = skid_data_q;
        skid_type_d = skid_type_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = in_if.data;
                        main_type_d = in_if.ntype;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data_d = in_if.data;
                        main_type_d = in_if.ntype;
                    end else if (accept && (SKID != 0)) begin
                        state_d     = FULL;
                        skid_data_d = in_if.data;
                        skid_type_d = in_if.ntype;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_type_d = skid_type_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers; reset clears everything so out_data reads 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_type_q <= '0;
            skid_data_q <= '0;
            skid_type_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_type_q <= main_type_d;
            skid_data_q <= skid_data_d;
            skid_type_q <= skid_type_d;
        end
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (out_valid && !out_if.ready),
        .count (stall_count)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!out_valid && out_if.ready),
        .count (bubble_count)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid and non-skid modes
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int CW = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [TW-1:0] in_type   = '0;

    always #5 clock = ~clock;

    pipe_stage_reg_if #(.DATA_W(DW), .TYPE_W(TW)) in_if0 ();
    pipe_stage_reg_if #(.DATA_W(DW), .TYPE_W(TW)) out_if0 ();
    pipe_stage_reg_if #(.DATA_W(DW), .TYPE_W(TW)) in_if1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .TYPE_W(TW)) out_if1 ();

    assign in_if0.valid  = in_valid;
    assign in_if0.data   = in_data;
    assign in_if0.ntype  = in_type;
    assign out_if0.ready = out_ready;
    assign in_if1.valid  = in_valid;
    assign in_if1.data   = in_data;
    assign in_if1.ntype  = in_type;
    assign out_if1.ready = out_ready;

    logic [CW-1:0] stall0, bub0, stall1, bub1;

    pipe_stage_reg #(.DATA_W(DW), .TYPE_W(TW), .SKID(1), .CNT_W(CW)) dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_if(in_if0), .out_if(out_if0),
        .stall_count(stall0), .bubble_count(bub0)
    );

    pipe_stage_reg #(.DATA_W(DW), .TYPE_W(TW), .SKID(0), .CNT_W(CW)) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_if(in_if1), .out_if(out_if1),
        .stall_count(stall1), .bubble_count(bub1)
    );

    logic          ov [2];
    logic          ir [2];
    logic [DW-1:0] od [2];
    logic [TW-1:0] ot [2];
    logic [CW-1:0] sc [2];
    logic [CW-1:0] bc [2];

    assign ov[0] = out_if0.valid;  assign ov[1] = out_if1.valid;
    assign ir[0] = in_if0.ready;   assign ir[1] = in_if1.ready;
    assign od[0] = out_if0.data;   assign od[1] = out_if1.data;
    assign ot[0] = out_if0.ntype;  assign ot[1] = out_if1.ntype;
    assign sc[0] = stall0;         assign sc[1] = stall1;
    assign bc[0] = bub0;           assign bc[1] = bub1;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } beat_t;

    beat_t mq [2][$];
    int    stall_m [2];
    int    bub_m [2];
    int    cap [2] = '{2, 1};
    int    sat = (1 << CW) - 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks every cycle against a queue model of each DUT's held beats
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                mq[d].delete();
                stall_m[d] = 0;
                bub_m[d]   = 0;
                chk($sformatf("dut%0d rst out_valid", d), ov[d], 0);
                chk($sformatf("dut%0d rst out_data", d), od[d], 0);
                chk($sformatf("dut%0d rst out_type", d), ot[d], 0);
                chk($sformatf("dut%0d rst in_ready", d), ir[d], 1);
                chk($sformatf("dut%0d rst stall", d), sc[d], 0);
                chk($sformatf("dut%0d rst bubble", d), bc[d], 0);
            end else begin
                automatic bit exp_v = (mq[d].size() != 0);
                automatic bit exp_r = (mq[d].size() < cap[d]) || (d == 1 && out_ready);
                automatic logic [TW-1:0] exp_t = exp_v ? mq[d][0].t : '0;
                chk($sformatf("dut%0d out_valid", d), ov[d], exp_v);
                chk($sformatf("dut%0d out_type", d), ot[d], exp_t);
                chk($sformatf("dut%0d in_ready", d), ir[d], exp_r);
                chk($sformatf("dut%0d stall_count", d), sc[d], stall_m[d]);
                chk($sformatf("dut%0d bubble_count", d), bc[d], bub_m[d]);
                if (exp_v) chk($sformatf("dut%0d out_data", d), od[d], mq[d][0].d);
                if (ov[d] && out_ready) begin
                    if (mq[d].size() == 0) chk($sformatf("dut%0d spurious beat", d), 1, 0);
                    else void'(mq[d].pop_front());
                end
                if (exp_v && !out_ready && stall_m[d] < sat) stall_m[d]++;
                if (!exp_v && out_ready && bub_m[d] < sat) bub_m[d]++;
                if (flush) mq[d].delete();
                else if (in_valid && exp_r) mq[d].push_back('{d: in_data, t: in_type});
            end
        end
    end

    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_type   = TW'($urandom_range(0, 15));
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; flush = 0; out_ready = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
    endtask

    initial begin
        do_reset();

        // Idle with out_ready=1 counts bubbles
        repeat (5) cyc(0, '0, 1, 0);
        chk("idle bubble_count", bub0, 5);
        chk("idle stall_count", stall0, 0);
        chk("idle out_type", ot[0], 0);

        // Back-to-back stream, one-cycle latency
        for (int i = 1; i <= 4; i++) begin
            cyc(1, DW'(i), 1, 0);
            chk("stream out_data", od[0], i);
            chk("stream in_ready", ir[0], 1);
        end
        cyc(0, '0, 1, 0);

        // Fill skid to FULL, hold off a third beat, then drain in order
        cyc(1, 32'hA, 0, 0);
        cyc(1, 32'hB, 0, 0);
        chk("full in_ready", ir[0], 0);
        cyc(1, 32'hC, 0, 0);
        cyc(1, 32'hC, 0, 0);
        cyc(1, 32'hC, 1, 0);
        cyc(1, 32'hC, 1, 0);
        repeat (3) cyc(0, '0, 1, 0);

        // Non-skid mode: in_ready follows out_ready combinationally
        cyc(0, '0, 0, 1);
        cyc(1, 32'h5, 0, 0);
        in_valid = 1; in_data = 32'h6; out_ready = 1;
        #1;
        chk("noskid comb in_ready", ir[1], 1);
        @(posedge clock);
        #1;
        chk("noskid out_data", od[1], 32'h6);
        cyc(0, '0, 1, 0);

        // Flush from FULL discards held beats and the incoming one
        cyc(1, 32'hA, 0, 0);
        cyc(1, 32'hB, 0, 0);
        cyc(1, 32'hF, 0, 1);
        chk("flush out_valid", ov[0], 0);
        chk("flush in_ready", ir[0], 1);
        repeat (3) cyc(0, '0, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 4);
        end

        // Stall counter saturation, then asynchronous reset mid-hold
        do_reset();
        cyc(1, 32'h77, 0, 0);
        repeat ((1 << CW) + 3) cyc(0, '0, 0, 0);
        chk("stall saturate", stall0, sat);
        chk("hold out_data", od[0], 32'h77);
        #2;
        reset = 0;
        #1;
        chk("async rst out_valid", ov[0], 0);
        chk("async rst stall", stall0, 0);
        chk("async rst out_data", od[0], 0);
        chk("async rst in_ready", ir[0], 1);
        @(posedge clock);
        #1;
        reset = 1;
        repeat (3) cyc(0, '0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
